// File: rtl/saph_pix_wr.sv
// saph_pix_wr: pixel write combiner for the render back end.
// Each incoming pixel is packed by saph_col_pack. Consecutive pixels that land in
// the same 32-bit framebuffer word are merged into one masked word write.
// There is one accumulator and one output register.
//
// Optional build macro: SAPH_PIXWR_FMTCHK_EN
//   When it is defined, pixels with an unknown format category are accepted and
//   dropped, and they set the sticky err flag.
//   When it is undefined, those pixels pack to 0 with their lane mask set, and
//   err stays 0.
//
// in_fmt layout (35 bits):
//   [2:0]   cat (0 ARGB, 1 RGB, 2 GREY, 3 PAL, others invalid)
//   [7:3]   b_pos   [10:8]  b_wm1  (channel width minus one)
//   [15:11] g_pos   [18:16] g_wm1
//   [23:19] r_pos   [26:24] r_wm1
//   [31:27] a_pos   [34:32] a_wm1
// in_col layout: [31:24] a, [23:16] r, [15:8] g, [7:0] b.
// GREY and PAL carry their single value (grey level / palette index) in b.

module saph_col_pack (
  input  logic [31:0] col,
  input  logic [34:0] fmt,
  output logic [31:0] pack_data
);
  localparam logic [2:0] CAT_ARGB = 3'd0;
  localparam logic [2:0] CAT_RGB  = 3'd1;
  localparam logic [2:0] CAT_GREY = 3'd2;
  localparam logic [2:0] CAT_PAL  = 3'd3;

  // Keep the low (wm1+1) bits of a channel and move them to bit position pos.
  function automatic logic [31:0] chan_place(input logic [7:0] v,
                                             input logic [4:0] pos,
                                             input logic [2:0] wm1);
    logic [7:0] m;
    m = 8'hFF >> (3'd7 - wm1);
    chan_place = {24'd0, (v & m)} << pos;
  endfunction

  logic [31:0] a_f;
  logic [31:0] r_f;
  logic [31:0] g_f;
  logic [31:0] b_f;

  // Place each channel into its field. Overlapping fields simply OR together.
  always_comb begin
    a_f = chan_place(col[31:24], fmt[31:27], fmt[34:32]);
    r_f = chan_place(col[23:16], fmt[23:19], fmt[26:24]);
    g_f = chan_place(col[15:8],  fmt[15:11], fmt[18:16]);
    b_f = chan_place(col[7:0],   fmt[7:3],   fmt[10:8]);
    case (fmt[2:0])
      CAT_ARGB: pack_data = a_f | r_f | g_f | b_f;
      CAT_RGB:  pack_data = r_f | g_f | b_f;
      CAT_GREY: pack_data = b_f;
      CAT_PAL:  pack_data = b_f;
      default:  pack_data = 32'd0;
    endcase
  end
endmodule

module saph_pix_wr #(
  parameter int ADDR_W = 30,
  parameter int IDX_W  = ADDR_W + 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_col,
  input  logic [34:0]       in_fmt,
  input  logic [2:0]        in_bpp,
  input  logic [IDX_W-1:0]  in_idx,
  input  logic              in_last,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [31:0]       wr_mask,
  output logic              err
);

  // Accumulator and output register state
  logic              acc_valid_q, acc_valid_d;
  logic [ADDR_W-1:0] acc_addr_q,  acc_addr_d;
  logic [2:0]        acc_bpp_q,   acc_bpp_d;
  logic [31:0]       acc_data_q,  acc_data_d;
  logic [31:0]       acc_mask_q,  acc_mask_d;
  logic              wr_valid_q,  wr_valid_d;
  logic [ADDR_W-1:0] wr_addr_q,   wr_addr_d;
  logic [31:0]       wr_data_q,   wr_data_d;
  logic [31:0]       wr_mask_q,   wr_mask_d;
  logic              err_q,       err_d;

  // Lane decode
  logic [31:0]       pack_data;
  logic [2:0]        bpp_eff;
  logic [ADDR_W-1:0] in_addr;
  logic [31:0]       lane_base;
  logic [4:0]        slot_msk;
  logic [4:0]        slot;
  logic [4:0]        lane_shift;
  logic [31:0]       lane_mask;
  logic [31:0]       lane_data;
  logic              slot_last;

  // Control
  logic              drop;
  logic              conflict;
  logic              complete;
  logic              out_free;
  logic              accept;
  logic [31:0]       merged_data;
  logic [31:0]       merged_mask;

  saph_col_pack u_pack (
    .col       (in_col),
    .fmt       (in_fmt),
    .pack_data (pack_data)
  );

  // Decode bpp into word address, slot, and lane position/mask
  always_comb begin
    bpp_eff = (in_bpp > 3'd5) ? 3'd5 : in_bpp;
    case (bpp_eff)
      3'd0: begin in_addr = in_idx[ADDR_W+4:5]; lane_base = 32'h0000_0001; end
      3'd1: begin in_addr = in_idx[ADDR_W+3:4]; lane_base = 32'h0000_0003; end
      3'd2: begin in_addr = in_idx[ADDR_W+2:3]; lane_base = 32'h0000_000F; end
      3'd3: begin in_addr = in_idx[ADDR_W+1:2]; lane_base = 32'h0000_00FF; end
      3'd4: begin in_addr = in_idx[ADDR_W:1];   lane_base = 32'h0000_FFFF; end
      default: begin in_addr = in_idx[ADDR_W-1:0]; lane_base = 32'hFFFF_FFFF; end
    endcase
    slot_msk   = 5'h1F >> bpp_eff;
    slot       = in_idx[4:0] & slot_msk;
    lane_shift = slot << bpp_eff;
    lane_mask  = lane_base << lane_shift;
    lane_data  = (pack_data & lane_base) << lane_shift;
    slot_last  = (slot == slot_msk);
  end

  // Handshake decisions: drop, conflict, complete, in_ready
  always_comb begin
`ifdef SAPH_PIXWR_FMTCHK_EN
    drop = (in_fmt[2:0] > 3'd3);
`else
    drop = 1'b0;
`endif
    conflict = in_valid && !drop && acc_valid_q &&
               ((in_addr != acc_addr_q) || (bpp_eff != acc_bpp_q));
    complete = in_last || slot_last;
    out_free = !wr_valid_q || wr_ready;
    if (rst) begin
      in_ready = 1'b0;
    end else if (conflict) begin
      in_ready = 1'b0;
    end else if (complete) begin
      in_ready = out_free;
    end else begin
      in_ready = 1'b1;
    end
    accept = in_valid && in_ready;
    // A repeated slot overwrites its lane: clear the lane, then OR.
    if (acc_valid_q) begin
      merged_data = (acc_data_q & ~lane_mask) | lane_data;
      merged_mask = acc_mask_q | lane_mask;
    end else begin
      merged_data = lane_data;
      merged_mask = lane_mask;
    end
  end

  // Next state of the accumulator, the output register and the error flag
  always_comb begin
    acc_valid_d = acc_valid_q;
    acc_addr_d  = acc_addr_q;
    acc_bpp_d   = acc_bpp_q;
    acc_data_d  = acc_data_q;
    acc_mask_d  = acc_mask_q;
    wr_valid_d  = wr_valid_q && !wr_ready;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_mask_d   = wr_mask_q;
    if (conflict && out_free) begin
      // Flush the accumulator. The waiting pixel is taken on a later cycle.
      wr_valid_d  = 1'b1;
      wr_addr_d   = acc_addr_q;
      wr_data_d   = acc_data_q;
      wr_mask_d   = acc_mask_q;
      acc_valid_d = 1'b0;
    end else if (accept && !drop) begin
      if (complete) begin
        wr_valid_d  = 1'b1;
        wr_addr_d   = in_addr;
        wr_data_d   = merged_data;
        wr_mask_d   = merged_mask;
        acc_valid_d = 1'b0;
      end else begin
        acc_valid_d = 1'b1;
        acc_addr_d  = in_addr;
        acc_bpp_d   = bpp_eff;
        acc_data_d  = merged_data;
        acc_mask_d  = merged_mask;
      end
    end else begin
      acc_valid_d = acc_valid_q;
    end
`ifdef SAPH_PIXWR_FMTCHK_EN
    err_d = err_q || (accept && drop);
`else
    err_d = 1'b0;
`endif
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_valid_q <= 1'b0;
      acc_addr_q  <= '0;
      acc_bpp_q   <= 3'd0;
      acc_data_q  <= 32'd0;
      acc_mask_q  <= 32'd0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 32'd0;
      wr_mask_q   <= 32'd0;
      err_q       <= 1'b0;
    end else begin
      acc_valid_q <= acc_valid_d;
      acc_addr_q  <= acc_addr_d;
      acc_bpp_q   <= acc_bpp_d;
      acc_data_q  <= acc_data_d;
      acc_mask_q  <= acc_mask_d;
      wr_valid_q  <= wr_valid_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_mask_q   <= wr_mask_d;
      err_q       <= err_d;
    end
  end

  assign wr_valid = wr_valid_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign wr_mask  = wr_mask_q;
  assign err      = err_q;

endmodule

// File: tb/tb_saph_pix_wr.sv
// Directed testbench for saph_pix_wr. Expected words are computed by hand.
module tb_saph_pix_wr;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_col;
  logic [34:0] in_fmt;
  logic [2:0]  in_bpp;
  logic [34:0] in_idx;
  logic        in_last;
  logic        wr_valid;
  logic        wr_ready;
  logic [29:0] wr_addr;
  logic [31:0] wr_data;
  logic [31:0] wr_mask;
  logic        err;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  logic [29:0] q_addr[$];
  logic [31:0] q_data[$];
  logic [31:0] q_mask[$];
  int          q_cyc[$];

  logic [34:0] FMT_ARGB, FMT_GREY8, FMT_GREY4, FMT_BAD;

  saph_pix_wr dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_col(in_col), .in_fmt(in_fmt), .in_bpp(in_bpp), .in_idx(in_idx),
    .in_last(in_last), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every write handshake. Inputs are stable at the falling edge.
  always @(negedge clk) begin
    if (!rst && wr_valid && wr_ready) begin
      q_addr.push_back(wr_addr);
      q_data.push_back(wr_data);
      q_mask.push_back(wr_mask);
      q_cyc.push_back(cyc);
    end
  end

  function automatic logic [34:0] mkfmt(input logic [2:0] cat,
      input logic [4:0] bp, input logic [2:0] bw, input logic [4:0] gp, input logic [2:0] gw,
      input logic [4:0] rp, input logic [2:0] rw, input logic [4:0] ap, input logic [2:0] aw);
    mkfmt = {aw, ap, rw, rp, gw, gp, bw, bp, cat};
  endfunction

  task automatic clear_q();
    q_addr.delete(); q_data.delete(); q_mask.delete(); q_cyc.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one pixel and hold it until accepted. Called just after a rising edge.
  task automatic send(input logic [31:0] col, input logic [34:0] fmt, input logic [2:0] bpp,
                      input logic [34:0] idx, input logic last,
                      output int waits, output int acc_cyc);
    in_valid = 1'b1; in_col = col; in_fmt = fmt; in_bpp = bpp; in_idx = idx; in_last = last;
    waits = 0;
    acc_cyc = -1;
    while (acc_cyc < 0) begin
      @(negedge clk);
      if (in_ready) begin
        acc_cyc = cyc;
      end else begin
        waits++;
        if (waits > 40) begin
          $display("FAIL send_timeout idx=%0d: in_ready stayed 0, required 1", idx);
          n_cmp++; n_err++;
          acc_cyc = cyc;
        end
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_ready = 1'b1;
    in_valid = 1'b1; in_col = 32'h1234_5678; in_fmt = FMT_ARGB; in_bpp = 3'd5;
    in_idx = 35'd0; in_last = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (in_ready !== 1'b0) begin $display("FAIL reset_in_ready got %b want 0", in_ready); n_err++; end
    in_valid = 1'b0; in_last = 1'b0;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (wr_valid !== 1'b0) begin $display("FAIL reset_wr_valid got %b want 0", wr_valid); n_err++; end
    n_cmp++; if (wr_addr !== 30'd0) begin $display("FAIL reset_wr_addr got %h want 0", wr_addr); n_err++; end
    n_cmp++; if (wr_data !== 32'd0) begin $display("FAIL reset_wr_data got %h want 0", wr_data); n_err++; end
    n_cmp++; if (wr_mask !== 32'd0) begin $display("FAIL reset_wr_mask got %h want 0", wr_mask); n_err++; end
    n_cmp++; if (err !== 1'b0) begin $display("FAIL reset_err got %b want 0", err); n_err++; end
    @(posedge clk); #1;
  endtask

  task automatic test_32bpp();
    int w, ac, ac0, wsum;
    logic [31:0] exp_d;
    clear_q(); wr_ready = 1'b1; wsum = 0; ac0 = 0;
    for (int i = 0; i < 4; i++) begin
      send(32'hA0B0C0D0 + i, FMT_ARGB, 3'd5, 35'(i), 1'b0, w, ac);
      wsum += w;
      if (i == 0) ac0 = ac;
    end
    idle(4);
    n_cmp++; if (wsum !== 0) begin $display("FAIL p32_stalls got %0d want 0", wsum); n_err++; end
    n_cmp++;
    if (q_addr.size() !== 4) begin
      $display("FAIL p32_count got %0d want 4", q_addr.size()); n_err++;
    end else begin
      n_cmp++; if (q_cyc[0] !== ac0 + 1) begin $display("FAIL p32_latency got cyc %0d want %0d", q_cyc[0], ac0 + 1); n_err++; end
      for (int i = 0; i < 4; i++) begin
        exp_d = 32'hA0B0C0D0 + i;
        n_cmp++; if (q_addr[i] !== 30'(i)) begin $display("FAIL p32_addr%0d got %h want %h", i, q_addr[i], i); n_err++; end
        n_cmp++; if (q_data[i] !== exp_d) begin $display("FAIL p32_data%0d got %h want %h", i, q_data[i], exp_d); n_err++; end
        n_cmp++; if (q_mask[i] !== 32'hFFFFFFFF) begin $display("FAIL p32_mask%0d got %h want ffffffff", i, q_mask[i]); n_err++; end
        n_cmp++; if (q_cyc[i] !== q_cyc[0] + i) begin $display("FAIL p32_cycle%0d got %0d want %0d", i, q_cyc[i], q_cyc[0] + i); n_err++; end
      end
    end
  endtask

  task automatic test_8bpp_grey();
    int w, ac;
    clear_q();
    for (int i = 0; i < 4; i++) send(32'h11 * (i + 1), FMT_GREY8, 3'd3, 35'(4 + i), 1'b0, w, ac);
    idle(4);
    n_cmp++;
    if (q_addr.size() !== 1) begin
      $display("FAIL g8_count got %0d want 1", q_addr.size()); n_err++;
    end else begin
      n_cmp++; if (q_addr[0] !== 30'd1) begin $display("FAIL g8_addr got %h want 1", q_addr[0]); n_err++; end
      n_cmp++; if (q_data[0] !== 32'h44332211) begin $display("FAIL g8_data got %h want 44332211", q_data[0]); n_err++; end
      n_cmp++; if (q_mask[0] !== 32'hFFFFFFFF) begin $display("FAIL g8_mask got %h want ffffffff", q_mask[0]); n_err++; end
    end
  endtask

  task automatic test_4bpp_last();
    int w, ac;
    clear_q();
    send(32'h0000000A, FMT_GREY4, 3'd2, 35'd3, 1'b1, w, ac);
    idle(3);
    n_cmp++;
    if (q_addr.size() !== 1) begin
      $display("FAIL g4_count got %0d want 1", q_addr.size()); n_err++;
    end else begin
      n_cmp++; if (q_addr[0] !== 30'd0) begin $display("FAIL g4_addr got %h want 0", q_addr[0]); n_err++; end
      n_cmp++; if (q_data[0] !== 32'h0000A000) begin $display("FAIL g4_data got %h want 0000a000", q_data[0]); n_err++; end
      n_cmp++; if (q_mask[0] !== 32'h0000F000) begin $display("FAIL g4_mask got %h want 0000f000", q_mask[0]); n_err++; end
    end
  endtask

  task automatic test_conflict();
    int w, ac;
    clear_q();
    send(32'h5A, FMT_GREY8, 3'd3, 35'd0, 1'b0, w, ac);
    send(32'h3C, FMT_GREY8, 3'd3, 35'd9, 1'b1, w, ac);
    n_cmp++; if (w !== 1) begin $display("FAIL cf_bubble got %0d want 1", w); n_err++; end
    idle(3);
    n_cmp++;
    if (q_addr.size() !== 2) begin
      $display("FAIL cf_count got %0d want 2", q_addr.size()); n_err++;
    end else begin
      n_cmp++; if (q_addr[0] !== 30'd0 || q_data[0] !== 32'h5A || q_mask[0] !== 32'hFF) begin
        $display("FAIL cf_word0 got %h/%h/%h want 0/5a/ff", q_addr[0], q_data[0], q_mask[0]); n_err++; end
      n_cmp++; if (q_addr[1] !== 30'd2 || q_data[1] !== 32'h3C00 || q_mask[1] !== 32'hFF00) begin
        $display("FAIL cf_word1 got %h/%h/%h want 2/3c00/ff00", q_addr[1], q_data[1], q_mask[1]); n_err++; end
    end
  endtask

  task automatic test_backpressure();
    int w, ac;
    logic [31:0] exp_d;
    clear_q(); wr_ready = 1'b0;
    send(32'hC0DE0010, FMT_ARGB, 3'd5, 35'd10, 1'b0, w, ac);
    in_valid = 1'b1; in_col = 32'hC0DE0011; in_fmt = FMT_ARGB; in_bpp = 3'd5; in_idx = 35'd11;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_cmp++; if (in_ready !== 1'b0) begin $display("FAIL bp_in_ready%0d got %b want 0", k, in_ready); n_err++; end
      n_cmp++; if (wr_valid !== 1'b1 || wr_addr !== 30'd10 || wr_data !== 32'hC0DE0010) begin
        $display("FAIL bp_hold%0d got %b/%h/%h want 1/a/c0de0010", k, wr_valid, wr_addr, wr_data); n_err++; end
    end
    @(posedge clk); #1;
    wr_ready = 1'b1;
    for (int i = 1; i < 4; i++) send(32'hC0DE0010 + i, FMT_ARGB, 3'd5, 35'(10 + i), 1'b0, w, ac);
    idle(4);
    n_cmp++;
    if (q_addr.size() !== 4) begin
      $display("FAIL bp_count got %0d want 4", q_addr.size()); n_err++;
    end else begin
      for (int i = 0; i < 4; i++) begin
        exp_d = 32'hC0DE0010 + i;
        n_cmp++; if (q_addr[i] !== 30'(10 + i) || q_data[i] !== exp_d) begin
          $display("FAIL bp_word%0d got %h/%h want %h/%h", i, q_addr[i], q_data[i], 10 + i, exp_d); n_err++; end
      end
    end
  endtask

  task automatic test_misc();
    int w, ac;
    // Repeated slot overwrites its lane.
    clear_q();
    send(32'h11, FMT_GREY8, 3'd3, 35'd0, 1'b0, w, ac);
    send(32'h22, FMT_GREY8, 3'd3, 35'd0, 1'b0, w, ac);
    send(32'h33, FMT_GREY8, 3'd3, 35'd1, 1'b1, w, ac);
    // bpp 7 behaves as 32 bpp.
    send(32'hCAFEBABE, FMT_ARGB, 3'd7, 35'd20, 1'b0, w, ac);
    // A bpp change at the same address is a conflict.
    send(32'h77, FMT_GREY8, 3'd3, 35'd0, 1'b0, w, ac);
    send(32'h0000BEEF, FMT_ARGB, 3'd4, 35'd1, 1'b1, w, ac);
    n_cmp++; if (w !== 1) begin $display("FAIL mx_bpp_bubble got %0d want 1", w); n_err++; end
    idle(3);
    n_cmp++;
    if (q_addr.size() !== 4) begin
      $display("FAIL mx_count got %0d want 4", q_addr.size()); n_err++;
    end else begin
      n_cmp++; if (q_addr[0] !== 30'd0 || q_data[0] !== 32'h3322 || q_mask[0] !== 32'hFFFF) begin
        $display("FAIL mx_overwrite got %h/%h/%h want 0/3322/ffff", q_addr[0], q_data[0], q_mask[0]); n_err++; end
      n_cmp++; if (q_addr[1] !== 30'd20 || q_data[1] !== 32'hCAFEBABE || q_mask[1] !== 32'hFFFFFFFF) begin
        $display("FAIL mx_bpp7 got %h/%h/%h want 14/cafebabe/ffffffff", q_addr[1], q_data[1], q_mask[1]); n_err++; end
      n_cmp++; if (q_addr[2] !== 30'd0 || q_data[2] !== 32'h77 || q_mask[2] !== 32'hFF) begin
        $display("FAIL mx_flush8 got %h/%h/%h want 0/77/ff", q_addr[2], q_data[2], q_mask[2]); n_err++; end
      n_cmp++; if (q_addr[3] !== 30'd0 || q_data[3] !== 32'hBEEF0000 || q_mask[3] !== 32'hFFFF0000) begin
        $display("FAIL mx_16bpp got %h/%h/%h want 0/beef0000/ffff0000", q_addr[3], q_data[3], q_mask[3]); n_err++; end
    end
  endtask

  task automatic test_mid_reset();
    int w, ac;
    clear_q();
    send(32'h99, FMT_GREY8, 3'd3, 35'd0, 1'b0, w, ac);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(3);
    n_cmp++; if (q_addr.size() !== 0 || wr_valid !== 1'b0) begin
      $display("FAIL rst_discard got %0d writes wr_valid=%b want 0/0", q_addr.size(), wr_valid); n_err++; end
    send(32'h66, FMT_GREY8, 3'd3, 35'd1, 1'b1, w, ac);
    idle(3);
    n_cmp++;
    if (q_addr.size() !== 1) begin
      $display("FAIL rst_after_count got %0d want 1", q_addr.size()); n_err++;
    end else begin
      n_cmp++; if (q_data[0] !== 32'h6600 || q_mask[0] !== 32'hFF00) begin
        $display("FAIL rst_after_word got %h/%h want 6600/ff00", q_data[0], q_mask[0]); n_err++; end
    end
  endtask

  task automatic test_fmtchk();
    int w, ac;
    clear_q();
`ifdef SAPH_PIXWR_FMTCHK_EN
    n_cmp++; if (err !== 1'b0) begin $display("FAIL fc_err_before got %b want 0", err); n_err++; end
    send(32'hDEADBEEF, FMT_BAD, 3'd5, 35'd0, 1'b0, w, ac);
    @(negedge clk);
    n_cmp++; if (err !== 1'b1) begin $display("FAIL fc_err_set got %b want 1", err); n_err++; end
    @(posedge clk); #1;
    send(32'h12345678, FMT_ARGB, 3'd5, 35'd1, 1'b1, w, ac);
    idle(3);
    n_cmp++;
    if (q_addr.size() !== 1) begin
      $display("FAIL fc_count got %0d want 1", q_addr.size()); n_err++;
    end else begin
      n_cmp++; if (q_addr[0] !== 30'd1 || q_data[0] !== 32'h12345678) begin
        $display("FAIL fc_word got %h/%h want 1/12345678", q_addr[0], q_data[0]); n_err++; end
    end
    n_cmp++; if (err !== 1'b1) begin $display("FAIL fc_err_sticky got %b want 1", err); n_err++; end
`else
    send(32'hDEADBEEF, FMT_BAD, 3'd5, 35'd0, 1'b0, w, ac);
    idle(3);
    n_cmp++;
    if (q_addr.size() !== 1) begin
      $display("FAIL fc_count got %0d want 1", q_addr.size()); n_err++;
    end else begin
      n_cmp++; if (q_addr[0] !== 30'd0 || q_data[0] !== 32'd0 || q_mask[0] !== 32'hFFFFFFFF) begin
        $display("FAIL fc_zero_word got %h/%h/%h want 0/0/ffffffff", q_addr[0], q_data[0], q_mask[0]); n_err++; end
    end
    n_cmp++; if (err !== 1'b0) begin $display("FAIL fc_err_tied got %b want 0", err); n_err++; end
`endif
  endtask

  initial begin
    FMT_ARGB  = mkfmt(3'd0, 5'd0, 3'd7, 5'd8, 3'd7, 5'd16, 3'd7, 5'd24, 3'd7);
    FMT_GREY8 = mkfmt(3'd2, 5'd0, 3'd7, 5'd0, 3'd0, 5'd0, 3'd0, 5'd0, 3'd0);
    FMT_GREY4 = mkfmt(3'd2, 5'd0, 3'd3, 5'd0, 3'd0, 5'd0, 3'd0, 5'd0, 3'd0);
    FMT_BAD   = mkfmt(3'd5, 5'd0, 3'd7, 5'd8, 3'd7, 5'd16, 3'd7, 5'd24, 3'd7);
    in_valid = 1'b0; in_col = 32'd0; in_fmt = 35'd0; in_bpp = 3'd0; in_idx = 35'd0;
    in_last = 1'b0; wr_ready = 1'b1; rst = 1'b1;
    test_reset();
    test_32bpp();
    test_8bpp_grey();
    test_4bpp_last();
    test_conflict();
    test_backpressure();
    test_misc();
    test_mid_reset();
    test_fmtchk();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
